// File: rtl/exe_div_unit.sv
// exe_div_unit: iterative radix-2 restoring divider for the EXE stage.
// Executes DIV (signed) and DIVU (unsigned). HI receives the remainder and
// LO the quotient. The EXE stage is held through stall_req while iterating.
// Optional feature macro: DIV_EARLY_TERM_EN. When defined, an operation whose
// dividend magnitude is below a non-zero divisor magnitude finishes at once.
module exe_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] div_hi,
    output logic [31:0] div_lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Magnitude of an operand; raw value for unsigned operations.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negation when the result sign is negative.
    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    logic [31:0] dvd_mag, dvs_mag;
    logic        sgn_q, sgn_r;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        no_borrow;
    logic [31:0] rem_step, quo_step;

    assign dvd_mag = abs32(dividend, is_signed);
    assign dvs_mag = abs32(divisor, is_signed);
    // Quotient is negative when operand signs differ; remainder follows dividend.
    assign sgn_q   = is_signed & (dividend[31] ^ divisor[31]);
    assign sgn_r   = is_signed & dividend[31];

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    // The shifted remainder can reach 33 bits; when its top bit is set the
    // subtraction always succeeds and the low 32 bits of the difference are exact.
    assign shifted   = {rem_q, quo_q[31]};
    assign trial     = {1'b0, shifted[31:0]} - {1'b0, dvs_q};
    assign no_borrow = shifted[32] | ~trial[32];
    assign rem_step  = no_borrow ? trial[31:0] : shifted[31:0];
    assign quo_step  = {quo_q[30:0], no_borrow};

    assign stall_req = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
    assign done      = done_q;
    assign div_hi    = hi_q;
    assign div_lo    = lo_q;

    // Next-state, iteration datapath and result write-back selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_d   = 32'd0;
                        quo_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        negq_d  = sgn_q;
                        negr_d  = sgn_r;
                        cnt_d   = 6'd0;
                        state_d = S_CALC;
`ifdef DIV_EARLY_TERM_EN
                        if ((dvs_mag != 32'd0) && (dvd_mag < dvs_mag)) begin
                            state_d = S_DONE;
                            hi_d    = apply_sign(dvd_mag, sgn_r);
                            lo_d    = 32'd0;
                            done_d  = 1'b1;
                        end
`endif
                    end
                end
                S_CALC: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_DONE;
                        hi_d    = apply_sign(rem_step, negr_q);
                        lo_d    = apply_sign(quo_step, negq_q);
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control state and architectural results, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Working registers; always reloaded on accept, so no reset is needed.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

endmodule
